// File: rtl/io_intf_pkg.sv
// Shared encodings for the wide host interface: commands, loopback modes and FSM states.
package io_intf_pkg;

    localparam logic [1:0] CMD_CONF  = 2'd0;
    localparam logic [1:0] CMD_START = 2'd1;
    localparam logic [1:0] CMD_DATA  = 2'd2;
    localparam logic [1:0] CMD_LAST  = 2'd3;

    localparam logic [1:0] LOOPBACK_NONE = 2'd0;
    localparam logic [1:0] LOOPBACK_DATA = 2'd1;
    localparam logic [1:0] LOOPBACK_CTRL = 2'd2;

    typedef enum logic [1:0] {
        S_CFG  = 2'd0,
        S_DATA = 2'd1,
        S_WAIT = 2'd2
    } state_e;

endpackage

// File: rtl/cfg_collector.sv
// Collects the hash configuration bytes (kk, nn, little-endian ll) from CONF beats.
module cfg_collector
    import io_intf_pkg::*;
#(
    parameter int unsigned LL_BYTES = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  conf_i,
    input  logic                  clr_i,
    input  logic [7:0]            byte_i,
    output logic [5:0]            kk_o,
    output logic [5:0]            nn_o,
    output logic [8*LL_BYTES-1:0] ll_o,
    output logic                  cfg_done_o
);

    localparam int unsigned CFG_BYTES = 2 + LL_BYTES;
    localparam int unsigned CNT_W     = $clog2(CFG_BYTES + 1);

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [5:0]            kk_q, kk_d;
    logic [5:0]            nn_q, nn_d;
    logic [8*LL_BYTES-1:0] ll_q, ll_d;

    always_comb begin
        cnt_d = cnt_q;
        kk_d  = kk_q;
        nn_d  = nn_q;
        ll_d  = ll_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (conf_i && cnt_q != CNT_W'(CFG_BYTES)) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(0)) begin
                kk_d = byte_i[5:0];
            end else if (cnt_q == CNT_W'(1)) begin
                nn_d = byte_i[5:0];
            end else begin
                // Shift in from the top so the first length byte lands least significant.
                ll_d = {byte_i, ll_q[8*LL_BYTES-1:8]};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            kk_q  <= '0;
            nn_q  <= '0;
            ll_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            kk_q  <= kk_d;
            nn_q  <= nn_d;
            ll_q  <= ll_d;
        end
    end

    assign kk_o       = kk_q;
    assign nn_o       = nn_q;
    assign ll_o       = ll_q;
    assign cfg_done_o = (cnt_q == CNT_W'(CFG_BYTES));

endmodule

// File: rtl/io_intf_wide.sv
// Wide host interface: config capture, block framing toward the core and a registered
// hash/loopback return path.
module io_intf_wide
    import io_intf_pkg::*;
#(
    parameter int unsigned BEAT_BYTES  = 1,
    parameter int unsigned BLOCK_BYTES = 64,
    parameter int unsigned LL_BYTES    = 8,
    parameter int unsigned IDX_W       = $clog2(BLOCK_BYTES)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    input  logic [1:0]              cmd_i,
    input  logic [8*BEAT_BYTES-1:0] data_i,
    input  logic [1:0]              loopback_mode_i,
    input  logic                    ready_v_i,
    input  logic                    hash_v_i,
    input  logic [8*BEAT_BYTES-1:0] hash_i,
    output logic                    hash_v_o,
    output logic [8*BEAT_BYTES-1:0] hash_o,
    output logic [5:0]              kk_o,
    output logic [5:0]              nn_o,
    output logic [8*LL_BYTES-1:0]   ll_o,
    output logic                    cfg_done_o,
    output logic                    data_v_o,
    output logic [8*BEAT_BYTES-1:0] data_o,
    output logic [IDX_W-1:0]        data_idx_o,
    output logic                    block_first_o,
    output logic                    block_last_o,
    output logic                    block_end_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_BYTES - BEAT_BYTES);

    state_e                  state_q, state_d;
    logic                    en_q;
    logic [1:0]              loopback_q;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    first_q, first_d;
    logic                    last_q, last_d;
    logic                    data_v_q, data_v_d;
    logic [8*BEAT_BYTES-1:0] data_q, data_d;
    logic [IDX_W-1:0]        data_idx_q, data_idx_d;
    logic                    end_q, end_d;
    logic                    hash_v_q, hash_v_d;
    logic [8*BEAT_BYTES-1:0] hash_q, hash_d;

    logic is_conf, acc, acc_conf, acc_data;
    logic [7:0] ctrl_byte;

    // CONF bypasses the WAIT stall so the host can always abort a held block.
    assign is_conf  = (cmd_i == CMD_CONF);
    assign ready_o  = en_q & ((state_q != S_WAIT) | is_conf);
    assign acc      = en_q & valid_i & ready_o;
    assign acc_conf = acc & is_conf;
    assign acc_data = acc & ~is_conf;

    cfg_collector #(
        .LL_BYTES(LL_BYTES)
    ) u_cfg (
        .clk       (clk),
        .reset     (reset),
        .conf_i    (acc_conf),
        .clr_i     (acc_data),
        .byte_i    (data_i[7:0]),
        .kk_o      (kk_o),
        .nn_o      (nn_o),
        .ll_o      (ll_o),
        .cfg_done_o(cfg_done_o)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        first_d    = first_q;
        last_d     = last_q;
        data_v_d   = acc_data;
        data_d     = data_q;
        data_idx_d = data_idx_q;
        end_d      = 1'b0;
        if (acc_conf) begin
            state_d = S_CFG;
            idx_d   = '0;
            first_d = 1'b0;
            last_d  = 1'b0;
        end else if (acc_data) begin
            data_d     = data_i;
            data_idx_d = idx_q;
            end_d      = (idx_q == LAST_IDX);
            idx_d      = idx_q + IDX_W'(BEAT_BYTES);
            state_d    = (idx_q == LAST_IDX) ? S_WAIT : S_DATA;
            if (idx_q == '0) begin
                first_d = (cmd_i == CMD_START);
                last_d  = (cmd_i == CMD_LAST);
            end else begin
                first_d = first_q | (cmd_i == CMD_START);
                last_d  = last_q | (cmd_i == CMD_LAST);
            end
        end else if (state_q == S_WAIT && ready_v_i) begin
            state_d = S_DATA;
        end
    end

    assign ctrl_byte = {1'b0, 2'(state_q), cmd_i, valid_i, ready_o, cfg_done_o};

    always_comb begin
        hash_d   = '0;
        hash_v_d = 1'b0;
        case (loopback_q)
            LOOPBACK_NONE: begin
                hash_d   = hash_i;
                hash_v_d = hash_v_i;
            end
            LOOPBACK_DATA: begin
                hash_d   = data_i;
                hash_v_d = acc;
            end
            default: begin
                hash_d[7:0] = ctrl_byte;
                hash_v_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_CFG;
            en_q       <= 1'b0;
            loopback_q <= LOOPBACK_NONE;
            idx_q      <= '0;
            first_q    <= 1'b0;
            last_q     <= 1'b0;
            data_v_q   <= 1'b0;
            data_q     <= '0;
            data_idx_q <= '0;
            end_q      <= 1'b0;
            hash_v_q   <= 1'b0;
            hash_q     <= '0;
        end else begin
            state_q    <= state_d;
            en_q       <= en_i;
            if (en_q) begin
                loopback_q <= loopback_mode_i;
            end
            idx_q      <= idx_d;
            first_q    <= first_d;
            last_q     <= last_d;
            data_v_q   <= data_v_d;
            data_q     <= data_d;
            data_idx_q <= data_idx_d;
            end_q      <= end_d;
            hash_v_q   <= hash_v_d;
            hash_q     <= hash_d;
        end
    end

    assign data_v_o      = data_v_q;
    assign data_o        = data_q;
    assign data_idx_o    = data_idx_q;
    assign block_first_o = first_q;
    assign block_last_o  = last_q;
    assign block_end_o   = end_q;
    assign hash_v_o      = hash_v_q;
    assign hash_o        = hash_q;

endmodule

// File: tb/tb_io_intf_wide.sv
// Directed bench for io_intf_wide with 4-byte beats, 64-byte blocks, 8-byte length.
module tb_io_intf_wide;
    import io_intf_pkg::*;

    localparam int unsigned BB = 4;
    localparam int unsigned BL = 64;
    localparam int unsigned LB = 8;

    logic          clk, reset, en_i, valid_i, ready_o, ready_v_i, hash_v_i;
    logic [1:0]    cmd_i, loopback_mode_i;
    logic [31:0]   data_i, hash_i, hash_o, data_o;
    logic          hash_v_o, cfg_done_o, data_v_o, block_first_o, block_last_o, block_end_o;
    logic [5:0]    kk_o, nn_o;
    logic [63:0]   ll_o;
    logic [5:0]    data_idx_o;

    int tests = 0;
    int fails = 0;

    io_intf_wide #(
        .BEAT_BYTES (BB),
        .BLOCK_BYTES(BL),
        .LL_BYTES   (LB)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .en_i           (en_i),
        .valid_i        (valid_i),
        .ready_o        (ready_o),
        .cmd_i          (cmd_i),
        .data_i         (data_i),
        .loopback_mode_i(loopback_mode_i),
        .ready_v_i      (ready_v_i),
        .hash_v_i       (hash_v_i),
        .hash_i         (hash_i),
        .hash_v_o       (hash_v_o),
        .hash_o         (hash_o),
        .kk_o           (kk_o),
        .nn_o           (nn_o),
        .ll_o           (ll_o),
        .cfg_done_o     (cfg_done_o),
        .data_v_o       (data_v_o),
        .data_o         (data_o),
        .data_idx_o     (data_idx_o),
        .block_first_o  (block_first_o),
        .block_last_o   (block_last_o),
        .block_end_o    (block_end_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [255:0] all;
        reset = 1'b1;
        #12;
        all = {ready_o, hash_v_o, hash_o, kk_o, nn_o, ll_o, cfg_done_o, data_v_o, data_o,
               data_idx_o, block_first_o, block_last_o, block_end_o};
        tests++;
        if (all !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got %h want 0", all);
        end
        reset = 1'b0;
        en_i  = 1'b1;
        step();
    endtask

    task automatic test_config();
        logic [7:0] cfg [10];
        cfg = '{8'h00, 8'h20, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        valid_i = 1'b1;
        cmd_i   = CMD_CONF;
        for (int i = 0; i < 10; i++) begin
            data_i = {24'hFFFFFF, cfg[i]};
            step();
        end
        tests++;
        if (kk_o !== 6'd0 || nn_o !== 6'd32 || ll_o !== 64'd64 || cfg_done_o !== 1'b1) begin
            fails++;
            $display("FAIL config: kk=%0d nn=%0d ll=%0d done=%b want 0 32 64 1",
                     kk_o, nn_o, ll_o, cfg_done_o);
        end
        data_i = 32'h0000_003F;
        step();
        valid_i = 1'b0;
        tests++;
        if (kk_o !== 6'd0 || nn_o !== 6'd32 || ll_o !== 64'd64 || cfg_done_o !== 1'b1) begin
            fails++;
            $display("FAIL config_saturate: kk=%0d nn=%0d ll=%0d done=%b want 0 32 64 1",
                     kk_o, nn_o, ll_o, cfg_done_o);
        end
        tests++;
        if (data_v_o !== 1'b0) begin
            fails++;
            $display("FAIL config_no_data: data_v=%b want 0", data_v_o);
        end
    endtask

    task automatic test_framing();
        int bad = 0;
        valid_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            cmd_i  = (i == 0) ? CMD_START : CMD_DATA;
            data_i = 32'h1000_0000 + i;
            step();
            if (data_v_o !== 1'b1 || data_idx_o !== 6'(4 * i) || data_o !== 32'h1000_0000 + i
                || block_first_o !== 1'b1 || block_last_o !== 1'b0
                || block_end_o !== (i == 15)) begin
                bad++;
                $display("FAIL framing_beat%0d: v=%b idx=%0d d=%h f=%b l=%b e=%b want 1 %0d %h 1 0 %b",
                         i, data_v_o, data_idx_o, data_o, block_first_o, block_last_o,
                         block_end_o, 4 * i, 32'h1000_0000 + i, i == 15);
            end
        end
        tests++;
        if (bad != 0) fails++;
        cmd_i = CMD_DATA;
        tests++;
        if (ready_o !== 1'b0 || cfg_done_o !== 1'b0) begin
            fails++;
            $display("FAIL framing_stall: ready=%b done=%b want 0 0", ready_o, cfg_done_o);
        end
        valid_i   = 1'b0;
        ready_v_i = 1'b1;
        step();
        ready_v_i = 1'b0;
        tests++;
        if (ready_o !== 1'b1 || data_v_o !== 1'b0) begin
            fails++;
            $display("FAIL framing_release: ready=%b data_v=%b want 1 0", ready_o, data_v_o);
        end
    endtask

    task automatic test_last_block();
        int bad = 0;
        valid_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            cmd_i  = (i == 0) ? CMD_LAST : CMD_DATA;
            data_i = 32'h2000_0000 + i;
            step();
            if (data_v_o !== 1'b1 || block_first_o !== 1'b0 || block_last_o !== 1'b1
                || data_idx_o !== 6'(4 * i)) begin
                bad++;
                $display("FAIL last_beat%0d: v=%b f=%b l=%b idx=%0d want 1 0 1 %0d",
                         i, data_v_o, block_first_o, block_last_o, data_idx_o, 4 * i);
            end
        end
        tests++;
        if (bad != 0) fails++;
        valid_i   = 1'b0;
        ready_v_i = 1'b1;
        step();
        ready_v_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        valid_i = 1'b1;
        cmd_i   = CMD_DATA;
        for (int i = 0; i < 16; i++) begin
            data_i = 32'h3000_0000 + i;
            step();
        end
        tests++;
        if (block_end_o !== 1'b1 || block_first_o !== 1'b0 || block_last_o !== 1'b0) begin
            fails++;
            $display("FAIL bp_block: end=%b f=%b l=%b want 1 0 0",
                     block_end_o, block_first_o, block_last_o);
        end
        data_i = 32'hBEEF_0001;
        for (int i = 0; i < 5; i++) begin
            step();
            if (data_v_o !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold%0d: data_v=%b want 0", i, data_v_o);
            end
        end
        tests++;
        if (bad != 0) fails++;
        ready_v_i = 1'b1;
        step();
        ready_v_i = 1'b0;
        tests++;
        if (data_v_o !== 1'b0) begin
            fails++;
            $display("FAIL bp_release_same_cycle: data_v=%b want 0", data_v_o);
        end
        step();
        valid_i = 1'b0;
        tests++;
        if (data_v_o !== 1'b1 || data_o !== 32'hBEEF_0001 || data_idx_o !== 6'd0) begin
            fails++;
            $display("FAIL bp_accept: v=%b d=%h idx=%0d want 1 beef0001 0",
                     data_v_o, data_o, data_idx_o);
        end
        step();
        tests++;
        if (data_v_o !== 1'b0) begin
            fails++;
            $display("FAIL bp_no_dup: data_v=%b want 0", data_v_o);
        end
    endtask

    task automatic test_abort();
        valid_i = 1'b1;
        cmd_i   = CMD_DATA;
        for (int i = 1; i < 16; i++) begin
            data_i = 32'h4000_0000 + i;
            step();
        end
        tests++;
        if (block_end_o !== 1'b1 || data_idx_o !== 6'd60) begin
            fails++;
            $display("FAIL abort_fill: end=%b idx=%0d want 1 60", block_end_o, data_idx_o);
        end
        valid_i         = 1'b0;
        loopback_mode_i = LOOPBACK_CTRL;
        step();
        valid_i = 1'b1;
        cmd_i   = CMD_CONF;
        data_i  = 32'h0000_0005;
        #1;
        tests++;
        if (ready_o !== 1'b1) begin
            fails++;
            $display("FAIL abort_ready: ready=%b want 1", ready_o);
        end
        step();
        valid_i = 1'b0;
        tests++;
        if (kk_o !== 6'd5 || nn_o !== 6'd32 || ll_o !== 64'd64 || data_v_o !== 1'b0
            || block_end_o !== 1'b0) begin
            fails++;
            $display("FAIL abort_cfg: kk=%0d nn=%0d ll=%0d v=%b e=%b want 5 32 64 0 0",
                     kk_o, nn_o, ll_o, data_v_o, block_end_o);
        end
        tests++;
        if (hash_v_o !== 1'b1 || hash_o !== 32'h0000_0046) begin
            fails++;
            $display("FAIL abort_ctrl_wait: v=%b h=%h want 1 00000046", hash_v_o, hash_o);
        end
        loopback_mode_i = LOOPBACK_NONE;
        hash_v_i        = 1'b0;
        hash_i          = 32'h0;
        step();
        tests++;
        if (hash_o !== 32'h0000_0002) begin
            fails++;
            $display("FAIL abort_ctrl_cfg: h=%h want 00000002", hash_o);
        end
        valid_i = 1'b1;
        cmd_i   = CMD_DATA;
        data_i  = 32'h5555_0000;
        step();
        valid_i = 1'b0;
        tests++;
        if (data_v_o !== 1'b1 || data_idx_o !== 6'd0 || block_first_o !== 1'b0
            || block_last_o !== 1'b0) begin
            fails++;
            $display("FAIL abort_restart: v=%b idx=%0d f=%b l=%b want 1 0 0 0",
                     data_v_o, data_idx_o, block_first_o, block_last_o);
        end
    endtask

    task automatic test_loopback();
        logic [255:0] all;
        loopback_mode_i = LOOPBACK_DATA;
        step();
        valid_i = 1'b1;
        cmd_i   = CMD_DATA;
        data_i  = 32'hA5A5_1234;
        step();
        valid_i = 1'b0;
        tests++;
        if (hash_v_o !== 1'b1 || hash_o !== 32'hA5A5_1234) begin
            fails++;
            $display("FAIL loop_data: v=%b h=%h want 1 a5a51234", hash_v_o, hash_o);
        end
        step();
        tests++;
        if (hash_v_o !== 1'b0) begin
            fails++;
            $display("FAIL loop_data_idle: v=%b want 0", hash_v_o);
        end
        loopback_mode_i = LOOPBACK_NONE;
        hash_v_i        = 1'b1;
        hash_i          = 32'h1122_3344;
        step();
        step();
        hash_v_i = 1'b0;
        tests++;
        if (hash_v_o !== 1'b1 || hash_o !== 32'h1122_3344) begin
            fails++;
            $display("FAIL loop_none: v=%b h=%h want 1 11223344", hash_v_o, hash_o);
        end
        en_i = 1'b0;
        step();
        loopback_mode_i = LOOPBACK_CTRL;
        valid_i         = 1'b1;
        cmd_i           = CMD_DATA;
        #1;
        tests++;
        if (ready_o !== 1'b0) begin
            fails++;
            $display("FAIL en_ready: ready=%b want 0", ready_o);
        end
        step();
        step();
        tests++;
        if (data_v_o !== 1'b0 || hash_v_o !== 1'b0) begin
            fails++;
            $display("FAIL en_gate: data_v=%b hash_v=%b want 0 0", data_v_o, hash_v_o);
        end
        en_i            = 1'b1;
        loopback_mode_i = LOOPBACK_NONE;
        step();
        step();
        reset = 1'b1;
        #1;
        all = {ready_o, hash_v_o, hash_o, kk_o, nn_o, ll_o, cfg_done_o, data_v_o, data_o,
               data_idx_o, block_first_o, block_last_o, block_end_o};
        tests++;
        if (all !== '0) begin
            fails++;
            $display("FAIL reset_midblock: got %h want 0", all);
        end
        valid_i = 1'b0;
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset           = 1'b1;
        en_i            = 1'b0;
        valid_i         = 1'b0;
        cmd_i           = CMD_CONF;
        data_i          = '0;
        loopback_mode_i = LOOPBACK_NONE;
        ready_v_i       = 1'b0;
        hash_v_i        = 1'b0;
        hash_i          = '0;
        test_reset();
        test_config();
        test_framing();
        test_last_block();
        test_back_to_back();
        test_abort();
        test_loopback();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/io_intf_wide.md
Name: io_intf_wide

Overview:
- Parametrised successor of the byte-serial host interface; accepts host beats of BEAT_BYTES bytes under a valid/ready handshake.
- Collects hash configuration (kk, nn, ll) and frames message beats into blocks of BLOCK_BYTES for the compression core, with first/last/end markers.
- Stalls the host while a full block waits for the core.
- Returns hash or loopback data through a registered output stage.

Parameters:
- BEAT_BYTES, 1, bytes per host beat; legal values 1, 2, 4; must divide BLOCK_BYTES.
- BLOCK_BYTES, 64, bytes per compression block; legal values 64 (2s) or 128 (2b).
- LL_BYTES, 8, width of the message-length field in bytes; legal values 8 or 16.
- IDX_W, $clog2(BLOCK_BYTES), width of the byte index.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- en_i  in  1  slice enable
- valid_i  in  1  host beat valid
- ready_o  out  1  host beat accepted when valid_i & ready_o
- cmd_i  in  2  0=CONF, 1=START, 2=DATA, 3=LAST
- data_i  in  8*BEAT_BYTES  beat payload; lane 0 = lowest byte
- loopback_mode_i  in  2  0=NONE, 1=DATA, 2/3=CTRL
- ready_v_i  in  1  core ready for the next block
- hash_v_i  in  1  core hash beat valid
- hash_i  in  8*BEAT_BYTES  core hash beat
- hash_v_o  out  1  output beat valid
- hash_o  out  8*BEAT_BYTES  output beat
- kk_o  out  6  key length
- nn_o  out  6  digest length
- ll_o  out  8*LL_BYTES  message length, little-endian
- cfg_done_o  out  1  all 2+LL_BYTES config bytes received
- data_v_o  out  1  message beat valid toward core
- data_o  out  8*BEAT_BYTES  message beat
- data_idx_o  out  IDX_W  byte index of lane 0 within the block
- block_first_o  out  1  current block carries START
- block_last_o  out  1  current block carries LAST
- block_end_o  out  1  data_v_o beat completes the block

Behaviour:
- Clock/reset: clk and async active-high reset.
- Reset values: every register and output is 0, including kk/nn/ll; state=S_CFG.
- Enable: en_q is en_i registered (reset 0). An accepted beat is acc = en_q & valid_i & ready_o.
- ready_o = en_q & ((state != S_WAIT) | cmd_i == CONF). It is combinational, and CONF is always accepted so the host can abort.
- States: S_CFG, S_DATA, S_WAIT.
  - Any accepted CONF: state→S_CFG, byte index←0, first/last flags←0.
  - S_CFG→S_DATA on an accepted non-CONF beat.
  - S_DATA→S_WAIT on an accepted beat with idx+BEAT_BYTES==BLOCK_BYTES.
  - S_WAIT→S_DATA when ready_v_i=1.
- Config collection:
  - Each accepted CONF consumes lane 0 only, indexed by cfg_cnt.
  - cfg_cnt=0 sets kk; 1 sets nn; 2..1+LL_BYTES shift into ll from the MSB (first byte ends up least significant).
  - cfg_cnt saturates at 2+LL_BYTES; further CONF beats are ignored and cfg_done_o stays 1.
  - An accepted non-CONF beat clears cfg_cnt and cfg_done_o. kk/nn/ll hold their values.
- Data path, latency 1:
  - On an accepted non-CONF beat: data_v_o=1 the next cycle, data_o=data_i, data_idx_o=idx before increment.
  - Index: idx += BEAT_BYTES, wrapping to 0 at BLOCK_BYTES.
  - block_end_o=1 with the beat whose data_idx_o==BLOCK_BYTES-BEAT_BYTES.
- Block flags:
  - On the beat with idx==0: first←(cmd==START), last←(cmd==LAST).
  - On later beats of the same block: the flag ORs in START/LAST, so flags are sticky per block.
  - Flags are visible on block_first_o/block_last_o from that beat's data_v_o cycle and hold until the next block's first beat.
- The host zero-pads the final block; partial blocks are not supported.
- Loopback: loopback_q loads loopback_mode_i when en_q (reset NONE). hash_v_o and hash_o are registered, latency 1.
  - NONE: hash_o←hash_i, hash_v_o←hash_v_i.
  - DATA: hash_o←data_i, hash_v_o←acc.
  - CTRL: hash_v_o←1. Lane 0 ←{1'b0, state[1:0], cmd_i, valid_i, ready_o, cfg_done_o}; other lanes ←0.
- Boundaries:
  - CONF arriving in S_WAIT aborts the held block; the core sees no block_end for it.
  - ready_v_i in S_WAIT in the same cycle as a valid beat: the beat is not accepted that cycle (ready_o is still low).
  - Reset mid-block drops the block and all flags.

Decomposition:
- Package io_intf_pkg holds:
  - cmd encodings CMD_CONF/START/DATA/LAST;
  - LOOPBACK_NONE/DATA/CTRL;
  - state enum S_CFG/S_DATA/S_WAIT.
- Sub-module cfg_collector (params LL_BYTES): cfg_cnt, kk/nn/ll registers, cfg_done_o.
- The top level holds the FSM, block framer and output stage.

Test Plan (BEAT_BYTES=4, BLOCK_BYTES=64, LL_BYTES=8):
- Config: 10 CONF beats with lane 0 = 0x00,0x20,0x40,0,0,0,0,0,0,0 → kk=0, nn=32, ll=64, cfg_done_o=1. An 11th CONF leaves all three unchanged.
- Framing: START beat then 15 DATA beats, no gaps → data_idx_o=0,4,…,60. block_first_o=1 from beat 0; block_end_o=1 only on idx 60; ready_o=0 the cycle after. Pulse ready_v_i → ready_o=1 next cycle.
- Last block: 16 beats with LAST on beat 0, following a START block → block_first_o=0, block_last_o=1 for the whole block.
- Backpressure: hold valid_i=1 in S_WAIT for 5 cycles → no data_v_o pulses. The beat is accepted the cycle after ready_v_i, and no data is lost or duplicated.
- Abort: in S_WAIT send CONF 0x05 → accepted. kk=5, state=S_CFG, next DATA beat has data_idx_o=0.
- Loopback: mode DATA, send beat 0xA5A5_1234 → hash_o=0xA5A5_1234 one cycle later with hash_v_o=1. With en_i=0, no beat is accepted and the mode does not change. Assert reset mid-block → all outputs 0.
